// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared state encoding and counter sizing for scan chain controllers
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    UNLOAD  = 2'd3
  } scan_state_e;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// rtl/scan_shift_reg.sv - parallel-load, left-shifting serial register with parallel read
module scan_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         fill,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-2:0], fill};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan test controller: pattern shift-in, capture, unload to parallel response
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 16,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  output logic                 scan_input,
  output logic                 scan_enable,
  input  logic                 scan_output,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CHAIN_LEN-1:0] res_data,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CHAIN_LEN + CAP_CYCLES);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYCLES - 1);

  scan_state_e          state;
  logic [CNT_W-1:0]     cnt;
  logic                 pending;
  logic                 accept;
  logic                 last;
  logic                 in_shift;
  logic                 out_shift;
  logic [CHAIN_LEN-1:0] in_q;
  logic [CHAIN_LEN-1:0] out_q;
  logic                 unused_bits;

  always_comb begin
    pat_ready = 1'b0;
    case (state)
      IDLE:    pat_ready = !res_valid;
      CAPTURE: pat_ready = !res_valid && !pending;
      default: pat_ready = 1'b0;
    endcase
  end

  assign accept    = pat_valid && pat_ready;
  assign last      = (cnt == '0);
  assign busy      = (state != IDLE);
  assign in_shift  = (state == SHIFT) || (state == UNLOAD && pending);
  assign out_shift = (state == UNLOAD);

  // Only the two head bits of in_sr and the low bits of out_sr feed the FSM.
  assign unused_bits = ^{in_q, out_q[CHAIN_LEN-1]};

  scan_shift_reg #(.W(CHAIN_LEN)) in_sr (
    .clk       (CK),
    .resetn    (RN),
    .load      (accept),
    .load_data (pat_data),
    .shift     (in_shift),
    .fill      (1'b0),
    .q         (in_q)
  );

  scan_shift_reg #(.W(CHAIN_LEN)) out_sr (
    .clk       (CK),
    .resetn    (RN),
    .load      (1'b0),
    .load_data ('0),
    .shift     (out_shift),
    .fill      (scan_output),
    .q         (out_q)
  );

  // scan_input is pre-loaded one edge ahead so the pin carries the bit the chain samples next.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      scan_enable <= 1'b0;
      scan_input  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            cnt         <= SHIFT_LAST;
            scan_enable <= 1'b1;
            scan_input  <= pat_data[CHAIN_LEN-1];
          end
        end
        SHIFT: begin
          if (last) begin
            state       <= CAPTURE;
            cnt         <= CAP_LAST;
            scan_enable <= 1'b0;
            scan_input  <= 1'b0;
          end else begin
            cnt        <= cnt - 1'b1;
            scan_input <= in_q[CHAIN_LEN-2];
          end
        end
        CAPTURE: begin
          if (accept) pending <= 1'b1;
          if (last) begin
            state       <= UNLOAD;
            cnt         <= SHIFT_LAST;
            scan_enable <= 1'b1;
            if (accept)       scan_input <= pat_data[CHAIN_LEN-1];
            else if (pending) scan_input <= in_q[CHAIN_LEN-1];
            else              scan_input <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UNLOAD: begin
          if (last) begin
            // A still-unconsumed response is kept rather than overwritten.
            if (!res_valid || res_ready) begin
              res_valid <= 1'b1;
              res_data  <= {out_q[CHAIN_LEN-2:0], scan_output};
            end
            scan_enable <= 1'b0;
            scan_input  <= 1'b0;
            if (pending) begin
              state   <= CAPTURE;
              cnt     <= CAP_LAST;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt        <= cnt - 1'b1;
            scan_input <= pending ? in_q[CHAIN_LEN-2] : 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - scoreboard bench for scan_chain_ctrl with an inverting chain model
module tb_scan_chain_ctrl;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        pat_valid = 1'b0;
  logic        pat_ready;
  logic [15:0] pat_data = '0;
  logic        scan_input;
  logic        scan_enable;
  logic        scan_output;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        busy;

  logic        s_pat_valid = 1'b0;
  logic        s_pat_ready;
  logic [4:0]  s_pat_data = '0;
  logic        s_scan_input;
  logic        s_scan_enable;
  logic        s_scan_output;
  logic        s_res_valid;
  logic        s_res_ready = 1'b1;
  logic [4:0]  s_res_data;
  logic        s_busy;

  logic [15:0] chain  = '0;
  logic [4:0]  chain6 = '0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   arrivals[$];
  exp_t mon_e;
  int   cyc = 0;
  int   se_low = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   prev_valid = 1'b0;

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  scan_chain_ctrl #(.CHAIN_LEN(16), .CAP_CYCLES(1)) dut (
    .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .scan_input(scan_input), .scan_enable(scan_enable), .scan_output(scan_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  scan_chain_ctrl #(.CHAIN_LEN(5), .CAP_CYCLES(3)) dut6 (
    .CK(CK), .RN(RN), .pat_valid(s_pat_valid), .pat_ready(s_pat_ready), .pat_data(s_pat_data),
    .scan_input(s_scan_input), .scan_enable(s_scan_enable), .scan_output(s_scan_output),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data), .busy(s_busy)
  );

  // Chain model: shift when SE=1, otherwise each functional cycle inverts every flop.
  assign scan_output   = chain[15];
  assign s_scan_output = chain6[4];
  always @(posedge CK) begin
    if (scan_enable) chain <= {chain[14:0], scan_input};
    else             chain <= ~chain;
    if (s_scan_enable) chain6 <= {chain6[3:0], s_scan_input};
    else               chain6 <= ~chain6;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CK) begin
    if (res_valid && !prev_valid) begin
      arrivals.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_res", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_latency", cyc, mon_e.due);
      end
    end
    if (busy && !scan_enable) se_low++;
    prev_valid = res_valid;
  end

  task automatic send(input logic [15:0] p, input bit expect_res, input logic [15:0] exp);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge CK);
    pat_data  = p;
    pat_valid = 1'b1;
    while (!pat_ready && waited < 200) begin
      @(negedge CK);
      waited++;
    end
    if (!pat_ready) begin
      check("accept_timeout", pat_ready, 1);
      pat_valid = 1'b0;
      return;
    end
    if (expect_res) begin
      e.data = exp;
      e.due  = cyc + 1 + 33;
      exp_q.push_back(e);
    end
    @(posedge CK);
    #1 pat_valid = 1'b0;
  endtask

  task automatic shift_expect(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      @(negedge CK);
      check("shift_se", scan_enable, 1);
      check("shift_si", scan_input, p[15-i]);
    end
    @(negedge CK);
    check("capture_se", scan_enable, 0);
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || busy || res_valid) && waited < 300) begin
      @(negedge CK);
      waited++;
    end
    check("drain", exp_q.size() + int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_se;
    int base_arr;
    int e0;
    int low;
    int waited;
    bit got;

    repeat (3) @(posedge CK);
    #1 RN = 1'b1;
    @(negedge CK);
    check("rst_se", scan_enable, 0);
    check("rst_si", scan_input, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_pat_ready", pat_ready, 1);
    check("rst6_res_valid", s_res_valid, 0);

    send(16'hA5C3, 1'b1, 16'h5A3C);
    shift_expect(16'hA5C3);
    wait_drain();

    send(16'h00FF, 1'b1, 16'hFF00);
    wait_drain();

    base_se  = se_low;
    base_arr = arrivals.size();
    send(16'h1234, 1'b1, 16'hEDCB);
    send(16'hFFFF, 1'b1, 16'h0000);
    wait_drain();
    check("overlap_se_low", se_low - base_se, 2);
    check("overlap_count", arrivals.size() - base_arr, 2);
    if (arrivals.size() - base_arr == 2)
      check("overlap_gap", arrivals[base_arr+1] - arrivals[base_arr], 17);

    res_ready = 1'b0;
    send(16'h0F0F, 1'b1, 16'hF0F0);
    waited = 0;
    while (!res_valid && waited < 100) begin
      @(negedge CK);
      waited++;
    end
    check("hold_valid", res_valid, 1);
    repeat (4) begin
      @(negedge CK);
      check("hold_pat_ready", pat_ready, 0);
      check("hold_busy", busy, 0);
      check("hold_res_data", res_data, 16'hF0F0);
    end
    res_ready = 1'b1;
    @(posedge CK);
    #1 res_ready = 1'b0;
    @(negedge CK);
    check("released_valid", res_valid, 0);
    check("released_pat_ready", pat_ready, 1);
    res_ready = 1'b1;
    wait_drain();

    send(16'h3C3C, 1'b0, 16'h0000);
    repeat (8) @(negedge CK);
    RN = 1'b0;
    @(posedge CK);
    #1 RN = 1'b1;
    @(negedge CK);
    check("midrst_se", scan_enable, 0);
    check("midrst_si", scan_input, 0);
    check("midrst_busy", busy, 0);
    check("midrst_res_valid", res_valid, 0);
    send(16'h6996, 1'b1, 16'h9669);
    shift_expect(16'h6996);
    wait_drain();

    @(negedge CK);
    s_pat_data  = 5'b10110;
    s_pat_valid = 1'b1;
    check("t6_pat_ready", s_pat_ready, 1);
    e0 = cyc + 1;
    @(posedge CK);
    #1 s_pat_valid = 1'b0;
    low = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CK);
      if (s_res_valid) begin
        got = 1'b1;
        check("t6_latency", cyc - e0, 13);
        check("t6_res_data", s_res_data, 5'b01001);
      end else if (s_busy && !s_scan_enable) begin
        low++;
      end
    end
    check("t6_got_res", got, 1);
    check("t6_se_low", low, 3);

    repeat (3) @(negedge CK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
